// File: rtl/avalon_read_arbiter.sv
// avalon_read_arbiter: shares one Avalon-MM read master between two requesters.
// Each requester posts a base byte address and a word count. Grants are
// round-robin and never preempted. Words are returned with a per-requester
// valid strobe, and completion is signalled with a one-cycle done pulse.
// Optional feature macro: ARB_TIMEOUT_EN adds an acknowledge watchdog that
// abandons a transaction after TIMEOUT_CYCLES READ cycles without an ack.
module avalon_read_arbiter #(
  parameter int INTERFACE_WIDTH_BITS = 128,
  parameter int INTERFACE_ADDR_BITS  = 26,
  parameter int LEN_BITS             = 10,
  parameter int TIMEOUT_CYCLES       = 255
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [1:0]                        req_start,
  input  logic [2*INTERFACE_ADDR_BITS-1:0]  req_base_address,
  input  logic [2*LEN_BITS-1:0]             req_length,
  output logic [1:0]                        req_busy,
  output logic [INTERFACE_WIDTH_BITS-1:0]   rd_data,
  output logic [1:0]                        rd_valid,
  output logic [LEN_BITS-1:0]               rd_index,
  output logic [1:0]                        req_done,
  output logic [1:0]                        req_error,
  output logic [INTERFACE_ADDR_BITS-1:0]    interface_address,
  output logic [INTERFACE_WIDTH_BITS/8-1:0] interface_byte_enable,
  output logic                              interface_read,
  output logic                              interface_write,
  input  logic [INTERFACE_WIDTH_BITS-1:0]   interface_read_data,
  input  logic                              interface_acknowledge
);

  localparam int                 AW        = INTERFACE_ADDR_BITS;
  localparam int                 BYTES     = INTERFACE_WIDTH_BITS / 8;
  localparam logic [AW-1:0]      ADDR_STEP = AW'(BYTES);
  localparam logic [LEN_BITS-1:0] LEN_ONE  = LEN_BITS'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    NEXT = 2'd2
  } state_t;

  state_t              state, state_next;

  logic [AW-1:0]       slot_addr [2];
  logic [LEN_BITS-1:0] slot_len  [2];
  logic                last_grant;
  logic                gnt;
  logic [LEN_BITS-1:0] count;
  logic [LEN_BITS-1:0] word_idx;
  logic                grant_vld;
  logic                grant_sel;
  logic                tmo_hit;
  logic [1:0]          busy_set;
  logic [1:0]          busy_clr;

  assign interface_read        = (state == READ);
  assign interface_byte_enable = '1;
  assign interface_write       = 1'b0;

  // A start is only accepted while the requester is idle; later pulses are dropped.
  assign busy_set = req_start & ~req_busy;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state, round-robin grant selection and busy release.
  always_comb begin
    state_next = state;
    grant_vld  = 1'b0;
    grant_sel  = 1'b0;
    busy_clr   = 2'b00;
    case (state)
      IDLE: begin
        if (req_busy != 2'b00) begin
          grant_vld = 1'b1;
          // On a tie the requester not granted last wins.
          grant_sel = (req_busy == 2'b11) ? ~last_grant : req_busy[1];
          if (slot_len[grant_sel] == '0) busy_clr[grant_sel] = 1'b1;
          else                           state_next = READ;
        end
      end
      READ: begin
        if (interface_acknowledge) begin
          state_next = NEXT;
        end else if (tmo_hit) begin
          state_next    = IDLE;
          busy_clr[gnt] = 1'b1;
        end
      end
      NEXT: begin
        if (count == LEN_ONE) begin
          state_next    = IDLE;
          busy_clr[gnt] = 1'b1;
        end else begin
          state_next = READ;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Pending-slot capture of base address and length on an accepted start.
  always_ff @(posedge clk) begin
    for (int r = 0; r < 2; r++) begin
      if (busy_set[r]) begin
        slot_addr[r] <= req_base_address[r*AW +: AW];
        slot_len[r]  <= req_length[r*LEN_BITS +: LEN_BITS];
      end
    end
  end

  // Transaction datapath: grant bookkeeping, address walk, read-data return.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_busy          <= '0;
      last_grant        <= 1'b1;
      gnt               <= 1'b0;
      interface_address <= '0;
      count             <= '0;
      word_idx          <= '0;
      rd_data           <= '0;
      rd_valid          <= '0;
      rd_index          <= '0;
      req_done          <= '0;
    end else begin
      rd_valid <= '0;
      req_done <= '0;
      req_busy <= (req_busy | busy_set) & ~busy_clr;
      case (state)
        IDLE: begin
          if (grant_vld) begin
            gnt               <= grant_sel;
            last_grant        <= grant_sel;
            interface_address <= slot_addr[grant_sel];
            count             <= slot_len[grant_sel];
            word_idx          <= '0;
            if (slot_len[grant_sel] == '0) req_done[grant_sel] <= 1'b1;
          end
        end
        READ: begin
          if (interface_acknowledge) begin
            rd_data       <= interface_read_data;
            rd_valid[gnt] <= 1'b1;
            rd_index      <= word_idx;
            if (count == LEN_ONE) req_done[gnt] <= 1'b1;
          end else if (tmo_hit) begin
            req_done[gnt] <= 1'b1;
          end
        end
        NEXT: begin
          // Address wraps silently at the top of the byte-address space.
          interface_address <= interface_address + ADDR_STEP;
          count             <= count - LEN_ONE;
          word_idx          <= word_idx + LEN_ONE;
        end
        default: ;
      endcase
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_cnt;

  assign tmo_hit = (state == READ) && !interface_acknowledge &&
                   (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Watchdog: counts READ cycles without ack, restarting on every READ entry.
  always_ff @(posedge clk) begin
    if (reset)               tmo_cnt <= '0;
    else if (state != READ)  tmo_cnt <= '0;
    else if (!tmo_hit)       tmo_cnt <= tmo_cnt + TW'(1);
  end

  // Error pulse, raised together with the done pulse on a watchdog expiry.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_error <= '0;
    end else begin
      req_error <= '0;
      if (tmo_hit) req_error[gnt] <= 1'b1;
    end
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

  assign tmo_hit   = 1'b0;
  assign req_error = 2'b00;
`endif

endmodule

// File: tb/tb_avalon_read_arbiter.sv
// tb_avalon_read_arbiter: directed and randomized bench for avalon_read_arbiter.
// The Avalon slave returns a fixed function of the address; a transaction-level
// scoreboard tracks each requester's base, length and word position.
module tb_avalon_read_arbiter;

  localparam int DW = 128;
  localparam int AW = 26;
  localparam int LW = 10;

  logic            clk;
  logic            reset;
  logic [1:0]      req_start;
  logic [2*AW-1:0] req_base_address;
  logic [2*LW-1:0] req_length;
  logic [1:0]      req_busy;
  logic [DW-1:0]   rd_data;
  logic [1:0]      rd_valid;
  logic [LW-1:0]   rd_index;
  logic [1:0]      req_done;
  logic [1:0]      req_error;
  logic [AW-1:0]   interface_address;
  logic [DW/8-1:0] interface_byte_enable;
  logic            interface_read;
  logic            interface_write;
  logic [DW-1:0]   interface_read_data;
  logic            interface_acknowledge;

  avalon_read_arbiter #(
    .INTERFACE_WIDTH_BITS(DW),
    .INTERFACE_ADDR_BITS (AW),
    .LEN_BITS            (LW),
    .TIMEOUT_CYCLES      (8)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .req_start            (req_start),
    .req_base_address     (req_base_address),
    .req_length           (req_length),
    .req_busy             (req_busy),
    .rd_data              (rd_data),
    .rd_valid             (rd_valid),
    .rd_index             (rd_index),
    .req_done             (req_done),
    .req_error            (req_error),
    .interface_address    (interface_address),
    .interface_byte_enable(interface_byte_enable),
    .interface_read       (interface_read),
    .interface_write      (interface_write),
    .interface_read_data  (interface_read_data),
    .interface_acknowledge(interface_acknowledge)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  typedef struct { int c; logic [AW-1:0] a; } rise_t;
  typedef struct { int c; int r; int idx; } rv_t;
  typedef struct { int c; int r; logic e; } dn_t;
  rise_t rise_q[$];
  rv_t   rv_q[$];
  dn_t   dn_q[$];

  // slave controls
  logic ack_en, rand_ack, force_ack, prev_read;
  int   ack_wait, wait_left, read_hi;
  logic err_ok;

  // transaction-level model
  logic [1:0]    busy_m;
  logic [1:0]    act_m;
  logic [AW-1:0] base_m [2];
  int            len_m  [2];
  int            idx_m  [2];
  int            n_words;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    logic [31:0] x;
    x = {6'd0, a};
    return {x * 32'h9E37_79B1, x ^ 32'hA5A5_5A5A, x + 32'h0123_4567, ~x};
  endfunction

  function automatic int first_done(input int r);
    foreach (dn_q[i]) if (dn_q[i].r == r) return dn_q[i].c;
    return -1;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    rise_q.delete();
    rv_q.delete();
    dn_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(1);
  endtask

  task automatic start(input logic [1:0] m, input logic [AW-1:0] b0, input logic [LW-1:0] l0,
                       input logic [AW-1:0] b1, input logic [LW-1:0] l1, output int t);
    req_base_address = {b1, b0};
    req_length       = {l1, l0};
    req_start        = m;
    t                = cyc;
    step(1);
    req_start = 2'b00;
  endtask

  task automatic wait_done(input int r, input int max);
    int k;
    k = 0;
    while (first_done(r) < 0 && k < max) begin
      step(1);
      k++;
    end
    chk($sformatf("wait_done%0d", r), first_done(r) >= 0, 1'b1);
  endtask

  // Avalon slave plus scoreboard, evaluated mid-cycle.
  task automatic monitor();
    logic [1:0] drop_after;
    drop_after = 2'b00;
    if (interface_read === 1'b1) read_hi++;
    if (interface_read === 1'b1 && prev_read !== 1'b1) begin
      rise_q.push_back('{cyc, interface_address});
      wait_left = rand_ack ? int'($urandom_range(0, 3)) : ack_wait;
    end
    prev_read = interface_read;
    interface_acknowledge = 1'b0;
    if (force_ack) begin
      interface_acknowledge = 1'b1;
      interface_read_data   = {$urandom, $urandom, $urandom, $urandom};
    end else if (interface_read === 1'b1 && ack_en) begin
      if (wait_left == 0) begin
        interface_acknowledge = 1'b1;
        interface_read_data   = mem_word(interface_address);
      end else begin
        wait_left--;
      end
    end
    if (reset) begin
      busy_m = 2'b00;
      act_m  = 2'b00;
      return;
    end
    if (rd_valid != 2'b00) chk("rd_valid_excl", $countones(rd_valid), 1);
    for (int r = 0; r < 2; r++) begin
      if (req_done[r]) dn_q.push_back('{cyc, r, req_error[r]});
      if (req_error[r]) chk("error_ok_with_done", {req_done[r], err_ok}, 2'b11);
      if (rd_valid[r]) begin
        rv_q.push_back('{cyc, r, int'(rd_index)});
        chk("valid_active", act_m[r], 1'b1);
        chk("rd_index", rd_index, idx_m[r]);
        chk("rd_data", rd_data, mem_word(base_m[r] + AW'(16 * idx_m[r])));
        idx_m[r]++;
        n_words++;
        chk("done_on_last", req_done[r], idx_m[r] == len_m[r]);
        if (idx_m[r] >= len_m[r]) begin
          act_m[r]      = 1'b0;
          drop_after[r] = 1'b1;
        end
      end else if (req_done[r]) begin
        chk("done_nodata", act_m[r] && (len_m[r] == 0 || req_error[r]), 1'b1);
        act_m[r]  = 1'b0;
        busy_m[r] = 1'b0;
      end
    end
    chk("req_busy", req_busy, busy_m);
    for (int r = 0; r < 2; r++) begin
      if (req_start[r] && !busy_m[r]) begin
        busy_m[r] = 1'b1;
        act_m[r]  = 1'b1;
        base_m[r] = req_base_address[r*AW +: AW];
        len_m[r]  = int'(req_length[r*LW +: LW]);
        idx_m[r]  = 0;
      end
    end
    busy_m = busy_m & ~drop_after;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    monitor();
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", n_total);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, t2, k;
    logic [AW-1:0] rb0, rb1;
    logic [LW-1:0] rl0, rl1;
    int exp_c [4];
    int exp_a [4];

    reset = 1'b1; req_start = 2'b00; req_base_address = '0; req_length = '0;
    interface_acknowledge = 1'b0; interface_read_data = '0;
    ack_en = 1'b1; rand_ack = 1'b0; force_ack = 1'b0; ack_wait = 1; wait_left = 0;
    prev_read = 1'b0; read_hi = 0; err_ok = 1'b0; busy_m = 2'b00; act_m = 2'b00; n_words = 0;
    step(3);
    reset = 1'b0;

    // reset state
    chk("rst_read", interface_read, 1'b0);
    chk("rst_busy", req_busy, 2'b00);
    chk("rst_valid", rd_valid, 2'b00);
    chk("rst_done", req_done, 2'b00);
    chk("rst_error", req_error, 2'b00);
    chk("rst_addr", interface_address, 0);
    chk("rst_data", rd_data, 0);
    chk("rst_index", rd_index, 0);
    chk("rst_be", interface_byte_enable, 16'hFFFF);
    chk("rst_write", interface_write, 1'b0);
    step(1);

    // single requester, three words, one wait cycle per ack
    clear_logs(); ack_wait = 1;
    start(2'b01, 26'd0, 10'd3, 26'd0, 10'd0, t0);
    wait_done(0, 100);
    step(2);
    chk("t1_rises", rise_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < rise_q.size()) begin
        chk("t1_addr", rise_q[i].a, 16 * i);
        chk("t1_rise_cyc", rise_q[i].c, t0 + 2 + 3 * i);
      end
      if (i < rv_q.size()) chk("t1_valid_cyc", rv_q[i].c, t0 + 4 + 3 * i);
    end
    chk("t1_done_cyc", first_done(0), t0 + 10);

    // simultaneous starts after reset: requester 0 first, zero-wait acks
    do_reset(); clear_logs(); ack_wait = 0;
    start(2'b11, 26'd204000, 10'd2, 26'd0, 10'd2, t0);
    wait_done(1, 100);
    step(2);
    exp_c = '{t0 + 2, t0 + 4, t0 + 7, t0 + 9};
    exp_a = '{204000, 204016, 0, 16};
    chk("t2_rises", rise_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < rise_q.size()) begin
        chk("t2_addr", rise_q[i].a, exp_a[i]);
        chk("t2_rise_cyc", rise_q[i].c, exp_c[i]);
      end
    end
    chk("t2_done0", first_done(0), t0 + 5);
    chk("t2_done1", first_done(1), t0 + 10);
    if (rise_q.size() > 2) chk("t2_r1_at_done_plus2", rise_q[2].c, first_done(0) + 2);

    // requester 0 alone, then a double start must favour requester 1
    clear_logs();
    start(2'b01, 26'd100, 10'd1, 26'd0, 10'd0, t1);
    wait_done(0, 50);
    step(2);
    clear_logs();
    start(2'b11, 26'd300, 10'd1, 26'd500, 10'd1, t2);
    wait_done(0, 50);
    step(2);
    chk("t2b_rises", rise_q.size(), 2);
    if (rise_q.size() > 1) begin
      chk("t2b_first_addr", rise_q[0].a, 500);
      chk("t2b_second_addr", rise_q[1].a, 300);
    end
    if (rv_q.size() > 0) chk("t2b_first_req", rv_q[0].r, 1);

    // zero-length transaction on requester 1
    clear_logs();
    start(2'b10, 26'd0, 10'd0, 26'h123450, 10'd0, t0);
    step(6);
    chk("t3_done_cyc", first_done(1), t0 + 2);
    chk("t3_no_read", rise_q.size(), 0);
    chk("t3_no_done0", first_done(0), -1);

    // address wrap at the top of the byte-address space
    clear_logs();
    start(2'b01, 26'h3FF_FFF0, 10'd2, 26'd0, 10'd0, t0);
    wait_done(0, 50);
    step(2);
    chk("t4_rises", rise_q.size(), 2);
    if (rise_q.size() > 1) begin
      chk("t4_addr0", rise_q[0].a, 26'h3FF_FFF0);
      chk("t4_addr1_wrap", rise_q[1].a, 0);
    end

    // reset while a read is outstanding, then a stray ack
    clear_logs(); ack_en = 1'b0;
    start(2'b01, 26'd64, 10'd4, 26'd0, 10'd0, t0);
    k = 0;
    while (interface_read !== 1'b1 && k < 10) begin
      step(1);
      k++;
    end
    chk("t5_read_up", interface_read, 1'b1);
    reset = 1'b1;
    step(1);
    chk("t5_read_dropped", interface_read, 1'b0);
    chk("t5_busy_cleared", req_busy, 2'b00);
    reset = 1'b0;
    step(1);
    force_ack = 1'b1;
    step(1);
    force_ack = 1'b0;
    chk("t5_stray_ack_valid", rd_valid, 2'b00);
    step(3);
    chk("t5_no_done", dn_q.size(), 0);
    chk("t5_no_valid", rv_q.size(), 0);

    // acknowledge never returned
    clear_logs(); read_hi = 0; err_ok = 1'b1;
    start(2'b01, 26'd0, 10'd3, 26'd0, 10'd0, t0);
`ifdef ARB_TIMEOUT_EN
    wait_done(0, 60);
    step(2);
    chk("t6_done_cyc", first_done(0), t0 + 10);
    if (dn_q.size() > 0) chk("t6_error_flag", dn_q[0].e, 1'b1);
    chk("t6_read_cycles", read_hi, 8);
    chk("t6_busy", req_busy, 2'b00);
`else
    step(40);
    chk("t6_read_held", interface_read, 1'b1);
    chk("t6_no_done", first_done(0), -1);
    chk("t6_no_error", req_error, 2'b00);
    do_reset();
`endif
    err_ok = 1'b0; ack_en = 1'b1;

    // randomized traffic with random ack latency
    do_reset(); clear_logs(); rand_ack = 1'b1; n_words = 0;
    for (int i = 0; i < 800; i++) begin
      rb0 = AW'($urandom); rb1 = AW'($urandom);
      rl0 = LW'($urandom_range(0, 4)); rl1 = LW'($urandom_range(0, 4));
      req_base_address = {rb1, rb0};
      req_length       = {rl1, rl0};
      req_start        = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
      step(1);
    end
    req_start = 2'b00;
    k = 0;
    while (busy_m != 2'b00 && k < 500) begin
      step(1);
      k++;
    end
    step(2);
    chk("rand_drained", busy_m, 2'b00);
    chk("rand_words_seen", n_words > 20, 1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
